// File: rtl/bin_maxpool2x2.sv
// bin_maxpool2x2
//   Downstream stage of the binary XNOR 3x3 convolution engine. Walks an
//   image list in the input SRAM and writes a list of the same shape to the
//   result SRAM. Each input map (header D, then D row words) becomes a map of
//   size Do = floor(D/2), built with a 2x2 stride-2 max-pool (logical OR).
//   The input terminator 16'h00FF is copied to the output and ends the pass.
//
// Ports
//   clk                     clock, all flops on posedge
//   reset_b                 asynchronous active-low reset
//   dut_run                 start request, sampled only in IDLE
//   dut_busy                high from start until the terminator is written
//   dut_sram_read_address   input SRAM address (registered)
//   sram_dut_read_data      input SRAM data, valid one cycle after the address
//   dut_sram_write_address  result SRAM address (registered)
//   dut_sram_write_data     result SRAM data (registered)
//   dut_sram_write_enable   one-cycle strobe per written word
//   dbg_state               current FSM state, for checkers
//
// Handshake: dut_run is a level seen only in IDLE; once accepted, dut_busy is
// high until the cycle after the terminator write, and dut_run is ignored
// while busy.
module bin_maxpool2x2 #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] IN_BASE  = '0,
    parameter logic [ADDR_W-1:0] OUT_BASE = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [2:0]        dbg_state
);

    localparam logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        ROW0 = 3'd2,
        ROW1 = 3'd3,
        WR   = 3'd4,
        SKIP = 3'd5,
        TERM = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   even_q, even_d;    // even row of the current pair
    logic [3:0]          do_q, do_d;        // output map size
    logic                odd_q, odd_d;      // input size was odd
    logic [3:0]          row_cnt_q, row_cnt_d;

    logic [4:0]          hdr_dim;
    logic [3:0]          hdr_do;
    logic [DATA_W-1:0]   row_or;
    logic [DATA_W-1:0]   col_mask;
    logic [DATA_W-1:0]   pooled;

    // Read pipeline: the data seen in a cycle belongs to the address that was
    // on the bus in the previous cycle. Each state therefore leaves the read
    // address one word ahead of the word it consumes; on entry to HDR the
    // address already points at the word after the header.
    always_comb begin
        hdr_dim  = (sram_dut_read_data[4:0] > 5'd16) ? 5'd16 : sram_dut_read_data[4:0];
        hdr_do   = hdr_dim[4:1];

        // Vertical OR of the row pair, then horizontal OR of column pairs.
        row_or   = even_q | sram_dut_read_data;
        col_mask = (DATA_W'(1) << do_q) - DATA_W'(1);
        pooled   = '0;
        for (int c = 0; c < DATA_W / 2; c++) begin
            pooled[c] = row_or[2*c] | row_or[2*c+1];
        end
        pooled   = pooled & col_mask;

        state_d   = state_q;
        busy_d    = busy_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = we_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        wr_data_d = wr_data_q;
        we_d      = 1'b0;
        even_d    = even_q;
        do_d      = do_q;
        odd_d     = odd_q;
        row_cnt_d = row_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (dut_run) begin
                    state_d   = HDR;
                    busy_d    = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            HDR: begin
                if (sram_dut_read_data == TERM_WORD) begin
                    // Hold the read address: nothing past terminator+1 is read.
                    state_d   = TERM;
                    we_d      = 1'b1;
                    wr_data_d = TERM_WORD;
                end else begin
                    do_d      = hdr_do;
                    odd_d     = hdr_dim[0];
                    row_cnt_d = '0;
                    we_d      = 1'b1;
                    wr_data_d = DATA_W'(hdr_do);
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (hdr_do != 4'd0) begin
                        state_d = ROW0;
                    end else if (hdr_dim[0]) begin
                        state_d = SKIP;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            ROW0: begin
                even_d    = sram_dut_read_data;
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                state_d   = ROW1;
            end
            ROW1: begin
                // Address stays on the next even row so WR can advance it.
                we_d      = 1'b1;
                wr_data_d = pooled;
                state_d   = WR;
            end
            WR: begin
                row_cnt_d = row_cnt_q + 4'd1;
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                if (row_cnt_q + 4'd1 < do_q) begin
                    state_d = ROW0;
                end else if (odd_q) begin
                    state_d = SKIP;
                end else begin
                    state_d = HDR;
                end
            end
            SKIP: begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                state_d   = HDR;
            end
            TERM: begin
                busy_d    = 1'b0;
                rd_addr_d = IN_BASE;
                wr_addr_d = OUT_BASE;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            rd_addr_q <= IN_BASE;
            wr_addr_q <= OUT_BASE;
            wr_data_q <= '0;
            we_q      <= 1'b0;
            even_q    <= '0;
            do_q      <= '0;
            odd_q     <= 1'b0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            we_q      <= we_d;
            even_q    <= even_d;
            do_q      <= do_d;
            odd_q     <= odd_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    assign dut_busy               = busy_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign dut_sram_write_enable  = we_q;
    assign dbg_state              = state_q;

endmodule

// File: tb/tb_bin_maxpool2x2.sv
module tb_bin_maxpool2x2;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] IN_BASE  = 12'h000;
    localparam logic [ADDR_W-1:0] OUT_BASE = 12'h000;

    logic              clk;
    logic              reset_b;
    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic [2:0]        dbg_state;

    bin_maxpool2x2 #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IN_BASE (IN_BASE),
        .OUT_BASE(OUT_BASE)
    ) dut (
        .clk                   (clk),
        .reset_b               (reset_b),
        .dut_run               (dut_run),
        .dut_busy              (dut_busy),
        .dut_sram_read_address (dut_sram_read_address),
        .sram_dut_read_data    (sram_dut_read_data),
        .dut_sram_write_address(dut_sram_write_address),
        .dut_sram_write_data   (dut_sram_write_data),
        .dut_sram_write_enable (dut_sram_write_enable),
        .dbg_state             (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- input SRAM model ----------------
    logic [15:0] in_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) sram_dut_read_data <= in_mem[dut_sram_read_address];

    // ---------------- scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int last_wr_cyc = 0;
    int max_rd = 0;
    int term_addr = 0;
    int ld_ptr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_b && dut_busy && int'(dut_sram_read_address) > max_rd)
            max_rd = int'(dut_sram_read_address);
        if (reset_b && dut_sram_write_enable) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {dut_sram_write_address, dut_sram_write_data}, 32'hDEAD_BEEF);
            end else begin
                check("write", {4'h0, dut_sram_write_address, dut_sram_write_data}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [15:0] w);
        in_mem[IN_BASE + ADDR_W'(ld_ptr)] = w;
        ld_ptr++;
    endtask

    task automatic put_map(input int d, input logic [15:0] even_w, input logic [15:0] odd_w);
        put(16'(d));
        for (int r = 0; r < d; r++) put((r % 2 == 0) ? even_w : odd_w);
    endtask

    // Reference model: parses the list in in_mem and pushes the expected writes.
    task automatic expect_list();
        int p;
        int wa;
        int d;
        int dq;
        logic [15:0] h;
        logic [15:0] o;
        logic [15:0] a;
        logic [15:0] b;
        p  = int'(IN_BASE);
        wa = int'(OUT_BASE);
        forever begin
            h = in_mem[p];
            if (h == 16'h00FF) begin
                exp_q.push_back({ADDR_W'(wa), 16'h00FF});
                term_addr = p;
                break;
            end
            d  = (int'(h[4:0]) > 16) ? 16 : int'(h[4:0]);
            dq = d / 2;
            exp_q.push_back({ADDR_W'(wa), 16'(dq)});
            wa++;
            for (int r = 0; r < dq; r++) begin
                a = in_mem[p + 1 + 2*r];
                b = in_mem[p + 2 + 2*r];
                o = '0;
                for (int c = 0; c < dq; c++)
                    o[c] = a[2*c] | a[2*c+1] | b[2*c] | b[2*c+1];
                exp_q.push_back({ADDR_W'(wa), o});
                wa++;
            end
            p = p + 1 + d;
        end
    endtask

    // Starts a pass (called at a negedge), waits for busy to fall, checks it all.
    task automatic run_list(input string tag, input int budget, output int busy_cycles);
        expect_list();
        max_rd = 0;
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        busy_cycles = 0;
        while (dut_busy && busy_cycles < budget) begin
            busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(dut_busy), 32'h0);
        check({tag, "_all_writes"}, 32'(exp_q.size()), 32'h0);
        check({tag, "_busy_fall"}, 32'(cyc), 32'(last_wr_cyc + 1));
        check({tag, "_read_bound"}, 32'(max_rd <= term_addr + 1), 32'h1);
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    int bc;
    int d_rand;
    initial begin
        reset_b = 1'b0;
        dut_run = 1'b0;
        for (int i = 0; i < 64; i++) in_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(dut_busy), 32'h0);
        check("rst_we", 32'(dut_sram_write_enable), 32'h0);
        check("rst_rd_addr", 32'(dut_sram_read_address), 32'(IN_BASE));
        check("rst_wr_addr", 32'(dut_sram_write_address), 32'(OUT_BASE));
        check("rst_wr_data", 32'(dut_sram_write_data), 32'h0);
        reset_b = 1'b1;
        @(negedge clk);

        // 8x8 alternating rows -> 4 rows of 000F
        ld_ptr = 0; put_map(8, 16'h00AA, 16'h0055); put(16'h00FF);
        run_list("t1_8x8", 2000, bc);

        // D=10 with one pixel in row 3, column 5 -> pooled row 1, column 2
        ld_ptr = 0; put(16'd10);
        for (int r = 0; r < 10; r++) put((r == 3) ? 16'h0020 : 16'h0000);
        put(16'h00FF);
        run_list("t2_d10", 2000, bc);

        // Back-to-back maps
        ld_ptr = 0; put_map(16, 16'hFFFF, 16'hFFFF); put_map(14, 16'h0000, 16'h0000); put(16'h00FF);
        run_list("t3_two_maps", 2000, bc);

        // D=9: odd row and odd column carry data but must be dropped
        ld_ptr = 0; put(16'd9); put(16'h0100);
        for (int r = 1; r < 8; r++) put(16'h0000);
        put(16'hFFFF); put(16'h00FF);
        run_list("t4_d9", 2000, bc);
        check("t4_term_at_10", 32'(term_addr), 32'd10);

        // Terminator only
        ld_ptr = 0; put(16'h00FF);
        run_list("t5_term_only", 2000, bc);
        check("t5_busy_len", 32'(bc <= 4), 32'h1);

        // Edge sizes: D=0, D=1, clamped D=20, plus random maps
        ld_ptr = 0;
        put(16'd0);
        put(16'd1); put(16'hFFFF);
        put(16'd20);
        for (int r = 0; r < 16; r++) put(16'($urandom_range(0, 16'hFFFF)));
        for (int m = 0; m < 3; m++) begin
            d_rand = $urandom_range(2, 16);
            put(16'(d_rand));
            for (int r = 0; r < d_rand; r++) put(16'($urandom_range(0, 16'hFFFF)));
        end
        put(16'h00FF);
        run_list("t6_edge_rand", 4000, bc);

        // Reset mid-map, then a full rerun
        ld_ptr = 0; put_map(16, 16'hFFFF, 16'hFFFF); put_map(14, 16'h0000, 16'h0000); put(16'h00FF);
        expect_list();
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset_b = 1'b0;
        #1;
        check("t7_rst_busy", 32'(dut_busy), 32'h0);
        check("t7_rst_we", 32'(dut_sram_write_enable), 32'h0);
        check("t7_rst_rd_addr", 32'(dut_sram_read_address), 32'(IN_BASE));
        check("t7_rst_wr_addr", 32'(dut_sram_write_address), 32'(OUT_BASE));
        check("t7_rst_wr_data", 32'(dut_sram_write_data), 32'h0);
        exp_q.delete();
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        run_list("t7_rerun", 2000, bc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
